// File: rtl/sim_stop_ctrl_if.sv
// sim_stop_ctrl_if: request/status bundle between testbench agents and the
// simulation-termination controller. Agents drive requests (master side);
// the controller drives the registered run status back (slave side).
interface sim_stop_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] done_req;
    logic [N-1:0] fail_req;
    logic         activity;
    logic [1:0]   state;
    logic         stop;
    logic         pass;
    logic         fail;
    logic [2:0]   reason;
    logic [63:0]  cycles;

    modport master (
        output done_req,
        output fail_req,
        output activity,
        input  state,
        input  stop,
        input  pass,
        input  fail,
        input  reason,
        input  cycles
    );

    modport slave (
        input  done_req,
        input  fail_req,
        input  activity,
        output state,
        output stop,
        output pass,
        output fail,
        output reason,
        output cycles
    );
endinterface

// File: rtl/sim_stop_ctrl.sv
// sim_stop_ctrl: collects done/fail requests from N agents, runs a global
// cycle timeout and an optional idle watchdog, drains for DRAIN cycles and
// then parks in a terminal STOPPED state reporting pass/fail and the reason.
// Optional build macro SIM_STOP_CTRL_FINISH_EN: when defined, the controller
// prints a stop message and calls $finish on the edge that enters STOPPED.
// Without it the design calls no system tasks at all.
module sim_stop_ctrl #(
    parameter int N          = 4,
    parameter int TIMEOUT    = 50000000,
    parameter int IDLE_LIMIT = 0,
    parameter int DRAIN      = 16
) (
    input logic            clk,
    input logic            rst,
    sim_stop_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    localparam logic [2:0] RSN_NONE    = 3'd0;
    localparam logic [2:0] RSN_DONE    = 3'd1;
    localparam logic [2:0] RSN_FAIL    = 3'd2;
    localparam logic [2:0] RSN_TIMEOUT = 3'd3;
    localparam logic [2:0] RSN_IDLE    = 3'd4;

    // Zero values disable the corresponding mechanism; the *_LAST constants
    // are the counter values seen on the edge that fires.
    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam bit          IDLE_EN      = (IDLE_LIMIT != 0);
    localparam bit          DRAIN_EN     = (DRAIN != 0);
    localparam logic [63:0] TIMEOUT_LAST = TIMEOUT_EN ? 64'(TIMEOUT - 1) : 64'd0;
    localparam logic [31:0] IDLE_LAST    = IDLE_EN ? 32'(IDLE_LIMIT - 1) : 32'd0;
    localparam logic [31:0] DRAIN_LAST   = DRAIN_EN ? 32'(DRAIN - 1) : 32'd0;

    // Saturating increments: counters stick at all ones instead of wrapping.
    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    state_t       state_q,     state_d;
    logic [N-1:0] done_mask_q, done_mask_d;
    logic [31:0]  idle_cnt_q,  idle_cnt_d;
    logic [31:0]  drain_cnt_q, drain_cnt_d;
    logic [63:0]  cycles_q,    cycles_d;
    logic         fail_q,      fail_d;
    logic [2:0]   reason_q,    reason_d;
    logic         stop_q,      stop_d;
    logic         pass_q,      pass_d;

    logic         any_fail;
    logic         timeout_hit;
    logic         idle_hit;
    logic         done_all;
    logic         run_exit;

    // Next-state, counter and status computation; everything lands in
    // registers so no input reaches an output combinationally.
    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        idle_cnt_d  = idle_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cycles_d    = cycles_q;
        fail_d      = fail_q;
        reason_d    = reason_q;
        any_fail    = |bus.fail_req;
        timeout_hit = 1'b0;
        idle_hit    = 1'b0;
        done_all    = 1'b0;
        run_exit    = 1'b0;

        case (state_q)
            ST_RUN: begin
                cycles_d    = sat_inc64(cycles_q);
                done_mask_d = done_mask_q | bus.done_req;
                done_all    = &done_mask_d;
                timeout_hit = TIMEOUT_EN && (cycles_q == TIMEOUT_LAST);

                // Idle counter tracks consecutive edges without progress.
                if (bus.activity) begin
                    idle_cnt_d = 32'd0;
                end else begin
                    idle_cnt_d = sat_inc32(idle_cnt_q);
                    idle_hit   = IDLE_EN && (idle_cnt_q >= IDLE_LAST);
                end

                run_exit = any_fail | timeout_hit | idle_hit | done_all;

                // Priority: failure, then timeout, then idle, then done.
                if (any_fail) begin
                    fail_d   = 1'b1;
                    reason_d = RSN_FAIL;
                end else if (timeout_hit) begin
                    fail_d   = 1'b1;
                    reason_d = RSN_TIMEOUT;
                end else if (idle_hit) begin
                    fail_d   = 1'b1;
                    reason_d = RSN_IDLE;
                end else if (done_all) begin
                    reason_d = RSN_DONE;
                end

                if (run_exit) begin
                    drain_cnt_d = 32'd0;
                    state_d     = DRAIN_EN ? ST_DRAIN : ST_STOPPED;
                end
            end

            ST_DRAIN: begin
                // Late failures still count; the stop reason is already fixed.
                cycles_d = sat_inc64(cycles_q);
                if (any_fail) begin
                    fail_d = 1'b1;
                end
                if (drain_cnt_q >= DRAIN_LAST) begin
                    state_d = ST_STOPPED;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                end
            end

            ST_STOPPED: begin
                state_d = ST_STOPPED;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        stop_d = (state_d == ST_STOPPED);
        pass_d = stop_d && !fail_d;
    end

    // State and status registers; reset restarts the run from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            done_mask_q <= '0;
            idle_cnt_q  <= 32'd0;
            drain_cnt_q <= 32'd0;
            cycles_q    <= 64'd0;
            fail_q      <= 1'b0;
            reason_q    <= RSN_NONE;
            stop_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            idle_cnt_q  <= idle_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cycles_q    <= cycles_d;
            fail_q      <= fail_d;
            reason_q    <= reason_d;
            stop_q      <= stop_d;
            pass_q      <= pass_d;
        end
    end

`ifdef SIM_STOP_CTRL_FINISH_EN
    // Self-terminating build: announce the stop and end the simulation on
    // the edge that enters STOPPED.
    always_ff @(posedge clk) begin
        if (!rst && (state_q != ST_STOPPED) && (state_d == ST_STOPPED)) begin
            $display("STOPPING SIMULATION: reason=%0d cycles=%0d pass=%0b",
                     reason_d, cycles_d, pass_d);
            $finish;
        end
    end
`else
    // Harness-terminated build: stop and pass are the only end-of-run
    // indications and the harness decides when to finish.
`endif

    assign bus.state  = state_q;
    assign bus.stop   = stop_q;
    assign bus.pass   = pass_q;
    assign bus.fail   = fail_q;
    assign bus.reason = reason_q;
    assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_sim_stop_ctrl.sv
// tb_sim_stop_ctrl: scoreboard bench for sim_stop_ctrl. Three instances share
// clock and reset: the main configuration (N=2, DRAIN=4, TIMEOUT=1000, idle
// watchdog off), one with IDLE_LIMIT=50, and one with DRAIN=0. Expected
// status snapshots are queued per edge and compared when that edge is reached.
module tb_sim_stop_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sim_stop_ctrl_if #(.N(2)) m_if ();
    sim_stop_ctrl_if #(.N(2)) i_if ();
    sim_stop_ctrl_if #(.N(2)) z_if ();

    sim_stop_ctrl #(.N(2), .TIMEOUT(1000), .IDLE_LIMIT(0), .DRAIN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    sim_stop_ctrl #(.N(2), .TIMEOUT(1000), .IDLE_LIMIT(50), .DRAIN(4)) dut_idle (
        .clk (clk),
        .rst (rst),
        .bus (i_if)
    );

    sim_stop_ctrl #(.N(2), .TIMEOUT(1000), .IDLE_LIMIT(0), .DRAIN(0)) dut_nodrain (
        .clk (clk),
        .rst (rst),
        .bus (z_if)
    );

    // Snapshot layout: {state, stop, pass, fail, reason, cycles}
    typedef struct {
        int          at;
        int          which;
        logic [71:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [71:0] mk(input logic [1:0] st, input logic stp,
                                       input logic ps, input logic fl,
                                       input logic [2:0] rs, input logic [63:0] cyc);
        return {st, stp, ps, fl, rs, cyc};
    endfunction

    function automatic logic [71:0] snap(input int which);
        case (which)
            1:       return {i_if.state, i_if.stop, i_if.pass, i_if.fail, i_if.reason, i_if.cycles};
            2:       return {z_if.state, z_if.stop, z_if.pass, z_if.fail, z_if.reason, z_if.cycles};
            default: return {m_if.state, m_if.stop, m_if.pass, m_if.fail, m_if.reason, m_if.cycles};
        endcase
    endfunction

    task automatic push(input int at, input int which, input string name, input logic [71:0] val);
        exp_t e;
        e.at = at; e.which = which; e.name = name; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] d, input logic [1:0] f, input logic act);
        m_if.done_req = d; m_if.fail_req = f; m_if.activity = act;
        i_if.done_req = d; i_if.fail_req = f; i_if.activity = act;
        z_if.done_req = d; z_if.fail_req = f; z_if.activity = act;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [71:0] got;
        rst = 1'b1;
        drive(2'b11, 2'b11, 1'b1);
        @(posedge clk); #1;
        for (int w = 0; w < 3; w++) begin
            got = snap(w);
            n_total++;
            if (got !== mk(2'd0, 0, 0, 0, 3'd0, 64'd0))
                $display("FAIL reset_values dut%0d: got %h expected %h", w, got, mk(2'd0, 0, 0, 0, 3'd0, 64'd0));
            else n_pass++;
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_normal_done();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(10, 0, "done_first_only", mk(2'd0, 0, 0, 0, 3'd0, 64'd10));
        push(19, 0, "done_mask_sticky", mk(2'd0, 0, 0, 0, 3'd0, 64'd19));
        push(20, 0, "done_enter_drain", mk(2'd1, 0, 0, 0, 3'd1, 64'd20));
        push(23, 0, "done_still_drain", mk(2'd1, 0, 0, 0, 3'd1, 64'd23));
        push(24, 0, "done_stopped", mk(2'd2, 1, 1, 0, 3'd1, 64'd24));
        push(30, 0, "done_held_fail_ignored", mk(2'd2, 1, 1, 0, 3'd1, 64'd24));
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            drive((k == 10) ? 2'b01 : (k == 20) ? 2'b10 : 2'b00,
                  (k == 27) ? 2'b01 : 2'b00, 1'b1);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL normal_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_fail_tie();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(4, 0, "tie_before", mk(2'd0, 0, 0, 0, 3'd0, 64'd4));
        push(5, 0, "tie_reason_fail", mk(2'd1, 0, 0, 1, 3'd2, 64'd5));
        push(8, 0, "tie_drain", mk(2'd1, 0, 0, 1, 3'd2, 64'd8));
        push(9, 0, "tie_stopped", mk(2'd2, 1, 0, 1, 3'd2, 64'd9));
        push(12, 0, "tie_held", mk(2'd2, 1, 0, 1, 3'd2, 64'd9));
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            drive((k == 5) ? 2'b11 : 2'b00, (k == 5) ? 2'b10 : 2'b00, 1'b1);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL tie_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(999, 0, "to_edge_999", mk(2'd0, 0, 0, 0, 3'd0, 64'd999));
        push(1000, 0, "to_fire", mk(2'd1, 0, 0, 1, 3'd3, 64'd1000));
        push(1004, 0, "to_stopped", mk(2'd2, 1, 0, 1, 3'd3, 64'd1004));
        push(1010, 0, "to_frozen", mk(2'd2, 1, 0, 1, 3'd3, 64'd1004));
        do_reset();
        for (int k = 1; k <= 1010; k++) begin
            drive(2'b00, 2'b00, 1'b1);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL timeout_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_idle();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(149, 1, "idle_not_yet", mk(2'd0, 0, 0, 0, 3'd0, 64'd149));
        push(150, 1, "idle_fire", mk(2'd1, 0, 0, 1, 3'd4, 64'd150));
        push(154, 1, "idle_stopped", mk(2'd2, 1, 0, 1, 3'd4, 64'd154));
        push(160, 0, "idle_disabled_main", mk(2'd0, 0, 0, 0, 3'd0, 64'd160));
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            drive(2'b00, 2'b00, (k <= 100) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL idle_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_late_fail();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(10, 0, "late_done_exit", mk(2'd1, 0, 0, 0, 3'd1, 64'd10));
        push(12, 0, "late_fail_set", mk(2'd1, 0, 0, 1, 3'd1, 64'd12));
        push(14, 0, "late_stopped", mk(2'd2, 1, 0, 1, 3'd1, 64'd14));
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            drive((k == 10) ? 2'b11 : 2'b00, (k == 12) ? 2'b01 : 2'b00, 1'b1);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL late_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(6, 0, "mr_in_drain", mk(2'd1, 0, 0, 0, 3'd1, 64'd6));
        push(7, 0, "mr_reset_values", mk(2'd0, 0, 0, 0, 3'd0, 64'd0));
        push(12, 0, "mr_mask_cleared", mk(2'd0, 0, 0, 0, 3'd0, 64'd5));
        push(15, 0, "mr_fresh_done", mk(2'd1, 0, 0, 0, 3'd1, 64'd8));
        push(19, 0, "mr_fresh_stop", mk(2'd2, 1, 1, 0, 3'd1, 64'd12));
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            rst = (k == 7);
            drive((k == 5) ? 2'b11 : (k == 10) ? 2'b01 : (k == 15) ? 2'b10 : 2'b00, 2'b00, 1'b1);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        rst = 1'b0;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL midreset_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_no_drain();
        exp_t e;
        logic [71:0] got;
        exp_q.delete();
        push(2, 2, "nd_before", mk(2'd0, 0, 0, 0, 3'd0, 64'd2));
        push(3, 0, "nd_main_drains", mk(2'd1, 0, 0, 0, 3'd1, 64'd3));
        push(3, 2, "nd_direct_stop", mk(2'd2, 1, 1, 0, 3'd1, 64'd3));
        push(6, 2, "nd_held", mk(2'd2, 1, 1, 0, 3'd1, 64'd3));
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive((k == 3) ? 2'b11 : 2'b00, (k == 5) ? 2'b11 : 2'b00, 1'b1);
            @(posedge clk); #1;
            while (exp_q.size() > 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front();
                got = snap(e.which);
                n_total++;
                if (got !== e.val) $display("FAIL %s edge %0d: got %h expected %h", e.name, k, got, e.val);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL nodrain_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        drive(2'b00, 2'b00, 1'b0);
        test_reset();
        test_normal_done();
        test_fail_tie();
        test_timeout();
        test_idle();
        test_late_fail();
        test_mid_reset();
        test_no_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sim_stop_ctrl.md
# sim_stop_ctrl

Simulation-termination controller for testbench tops. Collects completion and failure requests from up to N testbench agents, runs a global cycle timeout and an optional activity watchdog, then drains for a fixed number of cycles before entering a terminal stopped state. It replaces free-running stop timers wherever several agents must agree that a run is over, and reports pass/fail and stop reason to the harness.

## Interface

Parameters:
- N, 4, number of requesters (1..32)
- TIMEOUT, 50000000, cycles before forced stop; 0 disables
- IDLE_LIMIT, 0, consecutive inactive cycles before forced stop; 0 disables
- DRAIN, 16, cycles spent in DRAIN before STOPPED; 0 allowed

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  synchronous, active-high reset
- done_req  input  N  per-requester "finished"; any-cycle high latches sticky
- fail_req  input  N  per-requester error; any bit high for one cycle marks failure
- activity  input  1  high on any cycle with DUT progress; feeds watchdog
- state  output  2  0=RUN, 1=DRAIN, 2=STOPPED
- stop  output  1  high in STOPPED
- pass  output  1  high in STOPPED when no failure recorded
- fail  output  1  sticky failure flag
- reason  output  3  0=none, 1=done, 2=fail, 3=timeout, 4=idle
- cycles  output  64  cycles elapsed since reset

## Operation

- Reset (rst high at an edge): state=RUN, stop=0, pass=0, fail=0, reason=0, cycles=0, done mask=0, idle and drain counters=0. Reset mid-operation, including in STOPPED, fully restarts.
- "Edge k" = k-th rising edge after the edge where rst was last sampled high.
- RUN:
  - cycles increments each edge.
  - done mask |= done_req each edge.
  - Exit to DRAIN at an edge when any condition holds; reason set by priority FAIL > TIMEOUT > IDLE > DONE:
    - FAIL: any fail_req bit high → fail=1, reason=2.
    - TIMEOUT: TIMEOUT≠0 and this is edge TIMEOUT → fail=1, reason=3.
    - IDLE: IDLE_LIMIT≠0 and activity low on IDLE_LIMIT consecutive edges → fail=1, reason=4. Idle counter clears on any edge with activity high.
    - DONE: (done mask | done_req) all ones → reason=1.
- DRAIN:
  - cycles keeps incrementing; done_req, activity, timeout, and idle are ignored.
  - fail_req still sets fail=1; reason unchanged.
  - After DRAIN edges in DRAIN, go to STOPPED. DRAIN=0: RUN exits straight to STOPPED, same edge.
- STOPPED: terminal until rst. stop=1, pass=!fail, cycles frozen. fail_req ignored.
- cycles saturates at all ones and never wraps.

## Timing

- All outputs registered; no combinational input-to-output path.
- Exit condition sampled at edge k → state=DRAIN and reason visible after edge k.
- stop/pass valid after edge k+DRAIN (DRAIN≥1), or after edge k (DRAIN=0).
- pass and stop change on the same edge.
- fail rises on the edge where the failure is sampled, possibly before stop.
- Simultaneous fail and done on the exit edge resolve as reason=2, fail=1.

## Configuration

- SIM_STOP_CTRL_FINISH_EN defined: on the edge that enters STOPPED, $display "STOPPING SIMULATION" with reason and cycles, then call $finish.
- Not defined: no system tasks are called. The harness observes stop/pass and ends the run itself. All other behaviour is identical.

## Test plan

Common setup: N=2, DRAIN=4, TIMEOUT=1000, IDLE_LIMIT=0, SIM_STOP_CTRL_FINISH_EN undefined.

- Normal completion: done_req[0] pulses at edge 10, done_req[1] at edge 20 → state=1 after edge 20; stop=1, pass=1, reason=1, cycles=24 after edge 24 and held.
- Fail wins a tie: fail_req[1] and done_req=2'b11 both high at edge 5 → reason=2, fail=1 after edge 5; stop=1, pass=0 after edge 9.
- Timeout: no requests → state=1, reason=3, fail=1 after edge 1000; stop=1 after edge 1004; cycles frozen at 1004.
- Idle watchdog: IDLE_LIMIT=50, activity high through edge 100 then low → leaves RUN after edge 150 with reason=4; stop=1 after edge 154.
- Late failure: all done at edge 10, fail_req[0] at edge 12 → reason stays 1, fail=1; pass=0 at stop after edge 14.
- Mid-run reset: rst high for one edge while in DRAIN → all outputs at reset values; the previous done mask does not carry over, and a fresh done sequence completes normally.
